// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment bus capture block.
//   SEG_0..SEG_F : active-high segment patterns, a = bit 6 .. g = bit 0
//   state_e      : settle/hold states of the slot sampler
//   onehot_idx() : {ok, idx[1:0]}; ok=1 only when exactly one anode is selected
package seg_pkg;

   localparam logic [6:0] SEG_0 = 7'h7E;
   localparam logic [6:0] SEG_1 = 7'h30;
   localparam logic [6:0] SEG_2 = 7'h6D;
   localparam logic [6:0] SEG_3 = 7'h79;
   localparam logic [6:0] SEG_4 = 7'h33;
   localparam logic [6:0] SEG_5 = 7'h5B;
   localparam logic [6:0] SEG_6 = 7'h5F;
   localparam logic [6:0] SEG_7 = 7'h70;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h7B;
   localparam logic [6:0] SEG_A = 7'h77;
   localparam logic [6:0] SEG_B = 7'h1F;
   localparam logic [6:0] SEG_C = 7'h4E;
   localparam logic [6:0] SEG_D = 7'h3D;
   localparam logic [6:0] SEG_E = 7'h4F;
   localparam logic [6:0] SEG_F = 7'h47;

   typedef enum logic {
      ST_SETTLING = 1'b0,
      ST_HOLD     = 1'b1
   } state_e;

   function automatic logic [2:0] onehot_idx(input logic [3:0] an);
      logic [2:0] r;
      case (an)
         4'b0001: r = 3'b100;
         4'b0010: r = 3'b101;
         4'b0100: r = 3'b110;
         4'b1000: r = 3'b111;
         default: r = 3'b000;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational inverse of the segment encoder.
//   seg_i    : segments a..g (a = bit 6), active-high
//   valid_o  : 1 when seg_i is one of the sixteen hex glyphs
//   nibble_o : decoded value (0 when invalid)
module seg7_decode
   import seg_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic       valid_o,
   output logic [3:0] nibble_o
);

   always_comb begin
      valid_o  = 1'b1;
      nibble_o = 4'h0;
      case (seg_i)
         SEG_0:   nibble_o = 4'h0;
         SEG_1:   nibble_o = 4'h1;
         SEG_2:   nibble_o = 4'h2;
         SEG_3:   nibble_o = 4'h3;
         SEG_4:   nibble_o = 4'h4;
         SEG_5:   nibble_o = 4'h5;
         SEG_6:   nibble_o = 4'h6;
         SEG_7:   nibble_o = 4'h7;
         SEG_8:   nibble_o = 4'h8;
         SEG_9:   nibble_o = 4'h9;
         SEG_A:   nibble_o = 4'hA;
         SEG_B:   nibble_o = 4'hB;
         SEG_C:   nibble_o = 4'hC;
         SEG_D:   nibble_o = 4'hD;
         SEG_E:   nibble_o = 4'hE;
         SEG_F:   nibble_o = 4'hF;
         default: valid_o  = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_bus_capture.sv
// Receive side of a 4-digit multiplexed 7-segment bus. Each digit slot is
// sampled once after the bus has been stable for SETTLE cycles, decoded back
// to a nibble + dp, and a full 4-digit frame is published atomically.
//   clk, rst_n   : clock, asynchronous active-low reset
//   an_in        : one-hot digit select
//   sseg_in      : [6:0] segments a..g, [7] decimal point
//   hex0..hex3   : digits of the last complete frame
//   dp_out       : decimal points of the last complete frame
//   frame_valid  : 1-cycle pulse when hex*/dp_out update
//   seg_err      : 1-cycle pulse when a settled one-hot slot is undecodable
//   lost         : level, no accepted capture for STALL cycles
module seg_bus_capture
   import seg_pkg::*;
#(
   parameter int SETTLE = 16,
   parameter int STALL  = 2097152
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] an_in,
   input  logic [7:0] sseg_in,
   output logic [3:0] hex0,
   output logic [3:0] hex1,
   output logic [3:0] hex2,
   output logic [3:0] hex3,
   output logic [3:0] dp_out,
   output logic       frame_valid,
   output logic       seg_err,
   output logic       lost
);

   localparam int SCW = $clog2(SETTLE);
   localparam int STW = $clog2(STALL);
   localparam logic [SCW-1:0] STAB_LAST  = SCW'(SETTLE - 1);
   localparam logic [STW-1:0] STALL_LAST = STW'(STALL - 1);

   logic [11:0]      sync1_q, sync2_q, prev_q;
   state_e           state_q, state_d;
   logic [SCW-1:0]   stab_q, stab_d;
   logic [STW-1:0]   stall_q, stall_d;
   logic [3:0][3:0]  cap_hex_q, cap_hex_d;
   logic [3:0]       cap_dp_q, cap_dp_d;
   logic [3:0]       seen_q, seen_d;
   logic [3:0][3:0]  hex_q, hex_d;
   logic [3:0]       dp_q, dp_d;
   logic             fv_q, err_q, lost_q;
   logic             fv_d, err_d, lost_d;

   logic             changed, evaluate, capture, bad, stall_hit, frame_done;
   logic [2:0]       sel;
   logic             dec_valid;
   logic [3:0]       dec_nib;

   seg7_decode u_dec (
      .seg_i    (sync2_q[6:0]),
      .valid_o  (dec_valid),
      .nibble_o (dec_nib)
   );

   assign changed    = (sync2_q != prev_q);
   assign sel        = onehot_idx(sync2_q[11:8]);
   assign capture    = evaluate & sel[2] & dec_valid;
   assign bad        = evaluate & sel[2] & ~dec_valid;
   // A capture in the same cycle restarts the stall window instead of tripping it.
   assign stall_hit  = ~capture & (stall_q == STALL_LAST);
   assign frame_done = (seen_q == 4'hF);

   always_comb begin
      state_d  = state_q;
      stab_d   = stab_q;
      evaluate = 1'b0;
      if (changed) begin
         stab_d  = '0;
         state_d = ST_SETTLING;
      end else if (state_q == ST_SETTLING) begin
         if (stab_q == STAB_LAST) begin
            evaluate = 1'b1;
            state_d  = ST_HOLD;
         end else begin
            stab_d = stab_q + 1'b1;
         end
      end
   end

   always_comb begin
      cap_hex_d = cap_hex_q;
      cap_dp_d  = cap_dp_q;
      seen_d    = seen_q;
      hex_d     = hex_q;
      dp_d      = dp_q;
      fv_d      = frame_done;
      err_d     = bad;
      lost_d    = lost_q;
      stall_d   = stall_q;

      if (capture) begin
         stall_d = '0;
      end else if (stall_q != STALL_LAST) begin
         stall_d = stall_q + 1'b1;
      end

      // Publish the completed frame; the capture registers are stable here
      // because slot captures are always at least SETTLE cycles apart.
      if (frame_done) begin
         hex_d  = cap_hex_q;
         dp_d   = cap_dp_q;
         seen_d = 4'h0;
      end
      if (stall_hit) begin
         seen_d = 4'h0;
         lost_d = 1'b1;
      end
      if (capture) begin
         cap_hex_d[sel[1:0]] = dec_nib;
         cap_dp_d[sel[1:0]]  = sync2_q[7];
         seen_d[sel[1:0]]    = 1'b1;
         lost_d              = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
      end else begin
         sync1_q <= {an_in, sseg_in};
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_SETTLING;
         stab_q    <= '0;
         stall_q   <= '0;
         cap_hex_q <= '0;
         cap_dp_q  <= '0;
         seen_q    <= '0;
         hex_q     <= '0;
         dp_q      <= '0;
         fv_q      <= 1'b0;
         err_q     <= 1'b0;
         lost_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         stab_q    <= stab_d;
         stall_q   <= stall_d;
         cap_hex_q <= cap_hex_d;
         cap_dp_q  <= cap_dp_d;
         seen_q    <= seen_d;
         hex_q     <= hex_d;
         dp_q      <= dp_d;
         fv_q      <= fv_d;
         err_q     <= err_d;
         lost_q    <= lost_d;
      end
   end

   assign hex0        = hex_q[0];
   assign hex1        = hex_q[1];
   assign hex2        = hex_q[2];
   assign hex3        = hex_q[3];
   assign dp_out      = dp_q;
   assign frame_valid = fv_q;
   assign seg_err     = err_q;
   assign lost        = lost_q;

endmodule
